// File: rtl/ysyx_23060059_pkg.sv
// Shared types for the write-back unit: FSM states, CSR indices and the
// layout of the one-entry holding register.
package ysyx_23060059_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_HALT   = 2'd2
  } wbu_state_e;

  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;

  typedef struct packed {
    logic [31:0] wd;
    logic [31:0] csr_wd;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic        reg_en;
    logic        csreg_en;
    logic        ecall;
    logic        ebreak;
    logic        skip_d;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/Reg.sv
// Generic enabled register with asynchronous active-high reset.
module Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_23060059_csr_file.sv
// Four machine CSRs with a single write port; ecall writes mepc and mcause
// together and wins over a regular write to either of them.
module ysyx_23060059_csr_file
  import ysyx_23060059_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        ecall,
  input  logic [31:0] epc,
  output logic [31:0] mstatus,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic [31:0] mcause
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus <= '0;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      if (we) begin
        case (waddr)
          CSR_MSTATUS: mstatus <= wdata;
          CSR_MTVEC:   mtvec   <= wdata;
          CSR_MEPC:    mepc    <= wdata;
          default:     mcause  <= wdata;
        endcase
      end
      // Later assignment takes priority over the generic write above.
      if (ecall) begin
        mepc   <= epc;
        mcause <= ECALL_CAUSE;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060059_wbu.sv
// Write-back unit: holds one LSU result, performs its GPR/CSR writes once,
// then commits it to the IFU through a valid/ready handshake.
module ysyx_23060059_wbu
  import ysyx_23060059_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter int          CNT_W       = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             receive_valid,
  output logic             receive_ready,
  input  logic [31:0]      wd_i,
  input  logic [31:0]      csr_wd_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      pc_next_i,
  input  logic [31:0]      instruction_i,
  input  logic [4:0]       rd_i,
  input  logic [1:0]       csr_rd_i,
  input  logic             reg_en_i,
  input  logic             csreg_en_i,
  input  logic             ecall_i,
  input  logic             ebreak_i,
  input  logic             skip_d_i,
  output logic             reg_wen,
  output logic [4:0]       reg_waddr,
  output logic [31:0]      reg_wdata,
  output logic [31:0]      mstatus_o,
  output logic [31:0]      mtvec_o,
  output logic [31:0]      mepc_o,
  output logic [31:0]      mcause_o,
  output logic             send_valid,
  input  logic             send_ready,
  output logic [31:0]      pc_next_o,
  output logic [4:0]       rd_wbu_to_idu,
  output logic [1:0]       csr_rd_wbu_to_idu,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_inst,
  output logic             commit_skip_d,
  output logic             halt_o,
  output logic [CNT_W-1:0] instret_o
);

  wbu_state_e           state;
  logic                 fresh;
  logic                 accept;
  logic                 handshake;
  logic                 first_cycle;
  wb_entry_t            incoming;
  wb_entry_t            held;
  logic [ENTRY_W-1:0]   hold_q;

  assign incoming = '{wd: wd_i, csr_wd: csr_wd_i, pc: pc_i, pc_next: pc_next_i,
                      inst: instruction_i, rd: rd_i, csr_rd: csr_rd_i,
                      reg_en: reg_en_i, csreg_en: csreg_en_i, ecall: ecall_i,
                      ebreak: ebreak_i, skip_d: skip_d_i};

  Reg #(.WIDTH(ENTRY_W)) u_hold (
    .clock (clock),
    .reset (reset),
    .din   (incoming),
    .dout  (hold_q),
    .wen   (accept)
  );
  assign held = wb_entry_t'(hold_q);

  assign send_valid    = (state == S_COMMIT);
  assign handshake     = send_valid && send_ready;
  assign receive_ready = (state == S_IDLE) || (handshake && !held.ebreak);
  assign accept        = receive_valid && receive_ready;
  assign halt_o        = (state == S_HALT);

  // fresh marks the first COMMIT cycle of an entry; all side effects key off it.
  assign first_cycle = send_valid && fresh;
  assign reg_wen     = first_cycle && held.reg_en && (held.rd != 5'd0);
  assign reg_waddr   = held.rd;
  assign reg_wdata   = held.wd;

  assign pc_next_o     = held.pc_next;
  assign commit_pc     = held.pc;
  assign commit_inst   = held.inst;
  assign commit_skip_d = held.skip_d;

  assign rd_wbu_to_idu     = (send_valid && held.reg_en)   ? held.rd     : 5'd0;
  assign csr_rd_wbu_to_idu = (send_valid && held.csreg_en) ? held.csr_rd : 2'd0;

  ysyx_23060059_csr_file #(.ECALL_CAUSE(ECALL_CAUSE)) u_csr (
    .clock   (clock),
    .reset   (reset),
    .we      (first_cycle && held.csreg_en),
    .waddr   (held.csr_rd),
    .wdata   (held.csr_wd),
    .ecall   (first_cycle && held.ecall),
    .epc     (held.pc),
    .mstatus (mstatus_o),
    .mtvec   (mtvec_o),
    .mepc    (mepc_o),
    .mcause  (mcause_o)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fresh     <= 1'b0;
      instret_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_COMMIT;
            fresh <= 1'b1;
          end
        end
        S_COMMIT: begin
          fresh <= 1'b0;
          if (handshake) begin
            instret_o <= instret_o + CNT_W'(1);
            if (held.ebreak) begin
              state <= S_HALT;
            end else if (accept) begin
              fresh <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060059_wbu.sv
// Self-checking bench for the write-back unit: directed table, hand-written
// stall/ebreak/reset sequences, then randomized traffic against a model.
module tb_ysyx_23060059_wbu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [31:0] wd_i = '0, csr_wd_i = '0, pc_i = '0, pc_next_i = '0, instruction_i = '0;
  logic [4:0]  rd_i = '0;
  logic [1:0]  csr_rd_i = '0;
  logic        reg_en_i = 0, csreg_en_i = 0, ecall_i = 0, ebreak_i = 0, skip_d_i = 0;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [31:0] mstatus_o, mtvec_o, mepc_o, mcause_o;
  logic        send_valid;
  logic        send_ready = 1'b0;
  logic [31:0] pc_next_o;
  logic [4:0]  rd_wbu_to_idu;
  logic [1:0]  csr_rd_wbu_to_idu;
  logic [31:0] commit_pc, commit_inst;
  logic        commit_skip_d;
  logic        halt_o;
  logic [63:0] instret_o;

  ysyx_23060059_wbu dut (
    .clock(clock), .reset(reset),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .wd_i(wd_i), .csr_wd_i(csr_wd_i), .pc_i(pc_i), .pc_next_i(pc_next_i),
    .instruction_i(instruction_i), .rd_i(rd_i), .csr_rd_i(csr_rd_i),
    .reg_en_i(reg_en_i), .csreg_en_i(csreg_en_i), .ecall_i(ecall_i),
    .ebreak_i(ebreak_i), .skip_d_i(skip_d_i),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mstatus_o(mstatus_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mcause_o(mcause_o),
    .send_valid(send_valid), .send_ready(send_ready), .pc_next_o(pc_next_o),
    .rd_wbu_to_idu(rd_wbu_to_idu), .csr_rd_wbu_to_idu(csr_rd_wbu_to_idu),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_skip_d(commit_skip_d),
    .halt_o(halt_o), .instret_o(instret_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] wd, csr_wd, pc, pc_next, inst;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic        reg_en, csreg_en, ecall, ebreak, skip_d;
  } ent_t;

  typedef struct {
    ent_t        e;
    logic        exp_wen;
    logic [31:0] exp_mstatus, exp_mtvec, exp_mepc, exp_mcause;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input ent_t e);
    wd_i = e.wd; csr_wd_i = e.csr_wd; pc_i = e.pc; pc_next_i = e.pc_next;
    instruction_i = e.inst; rd_i = e.rd; csr_rd_i = e.csr_rd; reg_en_i = e.reg_en;
    csreg_en_i = e.csreg_en; ecall_i = e.ecall; ebreak_i = e.ebreak; skip_d_i = e.skip_d;
  endtask

  function automatic ent_t mk(input logic [4:0] rd, input logic [31:0] wd, input logic reg_en,
                              input logic csreg_en, input logic [1:0] csr_rd,
                              input logic [31:0] csr_wd, input logic ecall,
                              input logic ebreak, input logic [31:0] pc);
    ent_t e;
    e.rd = rd; e.wd = wd; e.reg_en = reg_en; e.csreg_en = csreg_en; e.csr_rd = csr_rd;
    e.csr_wd = csr_wd; e.ecall = ecall; e.ebreak = ebreak; e.pc = pc;
    e.pc_next = pc + 32'd4; e.inst = pc ^ 32'h00A0_0013; e.skip_d = pc[2];
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.wd = $urandom; e.csr_wd = $urandom; e.pc = $urandom; e.pc_next = $urandom;
    e.inst = $urandom; e.rd = 5'($urandom_range(0, 3)); e.csr_rd = 2'($urandom);
    e.reg_en = 1'($urandom); e.csreg_en = 1'($urandom);
    e.ecall = ($urandom % 6) == 0; e.ebreak = ($urandom % 40) == 0; e.skip_d = 1'($urandom);
    return e;
  endfunction

  task automatic chk_csrs(input string nm, input logic [31:0] s, input logic [31:0] t,
                          input logic [31:0] p, input logic [31:0] c);
    chk({nm, " mstatus"}, mstatus_o, s);
    chk({nm, " mtvec"}, mtvec_o, t);
    chk({nm, " mepc"}, mepc_o, p);
    chk({nm, " mcause"}, mcause_o, c);
  endtask

  // Asynchronous assert away from the edge, release between edges.
  task automatic apply_reset();
    reset = 1'b1; receive_valid = 1'b0; send_ready = 1'b0;
    #1;
    chk_csrs("reset", 0, 0, 0, 0);
    chk("reset instret", instret_o, 0);
    chk("reset send_valid", send_valid, 0);
    chk("reset reg_wen", reg_wen, 0);
    chk("reset halt", halt_o, 0);
    chk("reset hold pc", commit_pc, 0);
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("ready after reset", receive_ready, 1);
  endtask

  vec_t vecs[7];
  ent_t m_q[$];
  logic m_done;
  logic [31:0] m_csr[4];
  logic [63:0] m_instret;
  bit m_halted;

  initial begin
    logic [63:0] base;
    int halt_cnt;
    ent_t a, b, e;

    vecs[0] = '{mk(5, 32'h1234, 1, 0, 0, 0, 0, 0, 32'h8000_0000), 1, 0, 0, 0, 0};
    vecs[1] = '{mk(0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 32'h8000_0004), 0, 0, 0, 0, 0};
    vecs[2] = '{mk(0, 0, 0, 1, 2, 32'hDEAD_BEEF, 1, 0, 32'h8000_0010), 0, 0, 0, 32'h8000_0010, 11};
    vecs[3] = '{mk(31, 32'hA5A5_A5A5, 1, 1, 0, 32'h1888, 0, 0, 32'h8000_0014), 1,
                32'h1888, 0, 32'h8000_0010, 11};
    vecs[4] = '{mk(6, 32'h77, 0, 1, 1, 32'h8000_0100, 0, 0, 32'h8000_0018), 0,
                32'h1888, 32'h8000_0100, 32'h8000_0010, 11};
    vecs[5] = '{mk(0, 0, 0, 1, 3, 32'h55, 1, 0, 32'h8000_0020), 0,
                32'h1888, 32'h8000_0100, 32'h8000_0020, 11};
    vecs[6] = '{mk(2, 32'h9, 1, 1, 3, 32'h7, 0, 0, 32'h8000_0024), 1,
                32'h1888, 32'h8000_0100, 32'h8000_0020, 7};

    #3;
    apply_reset();

    base = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].e); receive_valid = 1'b1; send_ready = 1'b1;
      #1;
      chk("vec ready", receive_ready, 1);
      step();
      receive_valid = 1'b0;
      #1;
      chk("vec send_valid", send_valid, 1);
      chk("vec reg_wen", reg_wen, vecs[i].exp_wen);
      if (vecs[i].exp_wen) begin
        chk("vec waddr", reg_waddr, vecs[i].e.rd);
        chk("vec wdata", reg_wdata, vecs[i].e.wd);
      end
      chk("vec pc_next", pc_next_o, vecs[i].e.pc_next);
      chk("vec commit_pc", commit_pc, vecs[i].e.pc);
      chk("vec rd_to_idu", rd_wbu_to_idu, vecs[i].e.reg_en ? vecs[i].e.rd : 5'd0);
      chk("vec instret before", instret_o, base);
      step();
      base++;
      chk("vec idle", send_valid, 0);
      chk("vec wen idle", reg_wen, 0);
      chk("vec instret", instret_o, base);
      chk_csrs("vec", vecs[i].exp_mstatus, vecs[i].exp_mtvec, vecs[i].exp_mepc, vecs[i].exp_mcause);
    end

    // Stalled commit with a second entry waiting.
    a = mk(3, 32'h111, 1, 0, 0, 0, 0, 0, 32'h100);
    b = mk(7, 32'h222, 1, 0, 0, 0, 0, 0, 32'h200);
    drive(a); receive_valid = 1'b1; send_ready = 1'b0;
    step();
    drive(b);
    #1;
    chk("stall wen first", reg_wen, 1);
    chk("stall waddr", reg_waddr, 3);
    chk("stall ready", receive_ready, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("stall send_valid", send_valid, 1);
      chk("stall wen held", reg_wen, 0);
      chk("stall pc_next", pc_next_o, a.pc_next);
      chk("stall ready held", receive_ready, 0);
    end
    step();
    send_ready = 1'b1;
    #1;
    chk("stall ready on hs", receive_ready, 1);
    chk("stall instret", instret_o, base);
    step();
    receive_valid = 1'b0;
    #1;
    chk("b2b wen", reg_wen, 1);
    chk("b2b waddr", reg_waddr, 7);
    chk("b2b wdata", reg_wdata, 32'h222);
    chk("b2b commit_pc", commit_pc, b.pc);
    chk("b2b instret", instret_o, base + 1);
    step();
    chk("b2b idle", send_valid, 0);
    chk("b2b instret2", instret_o, base + 2);
    base += 2;

    // ebreak halts and ignores further traffic.
    e = mk(1, 32'h5, 0, 0, 0, 0, 0, 1, 32'h300);
    drive(e); receive_valid = 1'b1; send_ready = 1'b1;
    step();
    drive(mk(9, 32'hBAD, 1, 1, 0, 32'hBAD, 1, 0, 32'h400));
    #1;
    chk("ebreak ready", receive_ready, 0);
    step();
    chk("halt", halt_o, 1);
    chk("halt ready", receive_ready, 0);
    chk("halt send_valid", send_valid, 0);
    chk("halt instret", instret_o, base + 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("halt wen", reg_wen, 0);
    end
    chk_csrs("halt", 32'h1888, 32'h8000_0100, 32'h8000_0020, 7);
    chk("halt instret kept", instret_o, base + 1);

    // Reset during the first COMMIT cycle drops the pending writes.
    apply_reset();
    drive(mk(0, 0, 0, 1, 1, 32'h44, 0, 0, 32'h500)); receive_valid = 1'b1; send_ready = 1'b1;
    step(); receive_valid = 1'b0; step();
    chk("pre mtvec", mtvec_o, 32'h44);
    drive(mk(4, 32'h99, 1, 1, 0, 32'h99, 1, 0, 32'h600)); receive_valid = 1'b1; send_ready = 1'b0;
    step();
    receive_valid = 1'b0;
    #1;
    chk("mid commit valid", send_valid, 1);
    reset = 1'b1;
    #1;
    chk_csrs("mid reset", 0, 0, 0, 0);
    chk("mid reset wen", reg_wen, 0);
    step(); #1;
    reset = 1'b0;
    #1;
    chk("release ready", receive_ready, 1);
    step();
    chk_csrs("after release", 0, 0, 0, 0);
    chk("after release valid", send_valid, 0);
    chk("after release instret", instret_o, 0);

    // Randomized traffic against a transaction-level model.
    apply_reset();
    m_q.delete(); m_done = 0; m_instret = 0; m_halted = 0; halt_cnt = 0;
    foreach (m_csr[i]) m_csr[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ent_t r;
      bit busy, exp_ready, exp_wen, rv, sr;
      r = rand_ent(); rv = 1'($urandom); sr = ($urandom % 4) != 0;
      drive(r); receive_valid = rv; send_ready = sr;
      #1;
      busy = (m_q.size() != 0);
      exp_ready = !m_halted;
      if (busy) exp_ready = sr && !m_q[0].ebreak;
      exp_wen = busy && !m_done && m_q[0].reg_en && (m_q[0].rd != 0);
      chk("rnd ready", receive_ready, exp_ready);
      chk("rnd send_valid", send_valid, busy);
      chk("rnd halt", halt_o, m_halted);
      chk("rnd wen", reg_wen, exp_wen);
      if (exp_wen) begin
        chk("rnd waddr", reg_waddr, m_q[0].rd);
        chk("rnd wdata", reg_wdata, m_q[0].wd);
      end
      if (busy) begin
        chk("rnd pc_next", pc_next_o, m_q[0].pc_next);
        chk("rnd commit_pc", commit_pc, m_q[0].pc);
        chk("rnd commit_inst", commit_inst, m_q[0].inst);
        chk("rnd skip_d", commit_skip_d, m_q[0].skip_d);
        chk("rnd rd_to_idu", rd_wbu_to_idu, m_q[0].reg_en ? m_q[0].rd : 5'd0);
        chk("rnd csr_to_idu", csr_rd_wbu_to_idu, m_q[0].csreg_en ? m_q[0].csr_rd : 2'd0);
      end else begin
        chk("rnd rd_to_idu idle", rd_wbu_to_idu, 0);
        chk("rnd csr_to_idu idle", csr_rd_wbu_to_idu, 0);
      end
      chk_csrs("rnd", m_csr[0], m_csr[1], m_csr[2], m_csr[3]);
      chk("rnd instret", instret_o, m_instret);

      if (busy && !m_done) begin
        if (m_q[0].csreg_en) m_csr[m_q[0].csr_rd] = m_q[0].csr_wd;
        if (m_q[0].ecall) begin m_csr[2] = m_q[0].pc; m_csr[3] = 32'd11; end
        m_done = 1;
      end
      if (busy && sr) begin
        m_instret++;
        if (m_q[0].ebreak) m_halted = 1;
        void'(m_q.pop_front());
      end
      if (rv && exp_ready) begin m_q.push_back(r); m_done = 0; end
      step();

      if (m_halted) halt_cnt++;
      if (halt_cnt > 4) begin
        apply_reset();
        m_q.delete(); m_done = 0; m_instret = 0; m_halted = 0; halt_cnt = 0;
        foreach (m_csr[i]) m_csr[i] = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_23060059_wbu.md
YSYX_23060059_WBU -- requirements
Module: ysyx_23060059_wbu

Interface
REQ-001 SHALL have parameter ECALL_CAUSE, default 32'd11, value written to mcause on ecall.
REQ-002 SHALL have parameter CNT_W, default 64, width of the retired-instruction counter.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port receive_valid  in  1  LSU result valid.
REQ-006 SHALL have port receive_ready  out  1  WBU can accept an LSU result.
REQ-007 SHALL have ports wd_i/csr_wd_i/pc_i/pc_next_i/instruction_i  in  32 each  GPR data, CSR data, pc, next pc, instruction.
REQ-008 SHALL have ports rd_i  in  5; csr_rd_i  in  2; reg_en_i, csreg_en_i, ecall_i, ebreak_i, skip_d_i  in  1 each.
REQ-009 SHALL have ports reg_wen  out  1; reg_waddr  out  5; reg_wdata  out  32  GPR write port.
REQ-010 SHALL have ports mstatus_o, mtvec_o, mepc_o, mcause_o  out  32 each  CSR file contents.
REQ-011 SHALL have ports send_valid  out  1; send_ready  in  1; pc_next_o  out  32  commit handshake to IFU.
REQ-012 SHALL have ports rd_wbu_to_idu  out  5; csr_rd_wbu_to_idu  out  2  pending destinations for IDU hazard check.
REQ-013 SHALL have ports commit_pc  out  32; commit_inst  out  32; commit_skip_d  out  1; halt_o  out  1; instret_o  out  CNT_W.

Function
REQ-014 SHALL implement states IDLE, COMMIT, HALT.
REQ-015 SHALL drive receive_ready = (state==IDLE) || (state==COMMIT && send_ready && !ebreak of held entry).
REQ-016 SHALL latch all *_i inputs into a one-entry holding register on receive_valid && receive_ready; next state COMMIT.
REQ-017 SHALL assert reg_wen for exactly the first COMMIT cycle of each entry, only when reg_en==1 and rd!=0; rd==0 writes are dropped.
REQ-018 SHALL write csr_wd into CSR indexed by csr_rd (00 mstatus, 01 mtvec, 10 mepc, 11 mcause) on the first COMMIT cycle when csreg_en==1.
REQ-019 SHALL on ecall write mepc<=pc and mcause<=ECALL_CAUSE in the same cycle, overriding any csreg_en write to those two CSRs.
REQ-020 SHALL hold send_valid=1 and pc_next_o=held pc_next throughout COMMIT until send_ready sampled high.
REQ-021 SHALL on send_valid && send_ready: increment instret_o by 1 (wrap at 2^CNT_W-1 -> 0); go HALT if ebreak, COMMIT if a new entry is accepted the same cycle, else IDLE.
REQ-022 SHALL make back-to-back accept in COMMIT start a fresh one-cycle write strobe for the new entry.
REQ-023 SHALL drive commit_pc/commit_inst/commit_skip_d from the held entry, valid while send_valid==1.
REQ-024 SHALL drive rd_wbu_to_idu = held rd while state==COMMIT && reg_en, else 0; csr_rd_wbu_to_idu = held csr_rd while COMMIT && csreg_en, else 0.
REQ-025 SHALL in HALT drive halt_o=1, receive_ready=0, send_valid=0 and ignore all inputs until reset.
REQ-026 SHALL perform no GPR/CSR write and no counter change in IDLE or HALT.

Reset
REQ-027 SHALL on reset assertion immediately force state=IDLE, all CSRs=0, instret_o=0, holding register=0, send_valid=0, reg_wen=0, halt_o=0.
REQ-028 SHALL drop an in-flight COMMIT entry on reset mid-operation without performing its writes after reset release.
REQ-029 SHALL drive receive_ready=1 in the first cycle after reset deassertion.

Structure
REQ-030 SHALL place the state encoding and CSR index constants (MSTATUS=0, MTVEC=1, MEPC=2, MCAUSE=3) in the shared ysyx_23060059 package.
REQ-031 SHALL implement the CSR file as sub-module ysyx_23060059_csr_file (4x32, one write port, ecall dual write).
REQ-032 SHALL use the codebase Reg primitive for the holding register.

Verification
REQ-033 SHALL cover: accept rd=5, wd=0x1234, reg_en=1, send_ready=1 -> reg_wen one cycle, waddr=5, wdata=0x1234, instret 0->1.
REQ-034 SHALL cover: rd=0, reg_en=1, wd=0xFFFFFFFF -> reg_wen stays 0, instret increments.
REQ-035 SHALL cover: ecall at pc=0x80000010 with csreg_en=1, csr_rd=2 -> mepc=0x80000010, mcause=11, pc_next_o=pc_next_i.
REQ-036 SHALL cover: send_ready low 3 cycles then high, second entry valid throughout -> send_valid held, reg_wen single pulse, second entry accepted on handshake cycle, two retires.
REQ-037 SHALL cover: ebreak entry -> after handshake halt_o=1, receive_ready=0 and a following receive_valid causes no writes.
REQ-038 SHALL cover: reset asserted mid-COMMIT with csreg_en=1 -> all CSRs=0 and no write after release.
